// File: rtl/rv_isa_pkg.sv
// rv_isa_pkg: RV32I opcodes, instruction formats and encode helpers shared by the encoder and decoder.
package rv_isa_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD} fmtT;

  function automatic fmtT opFormat(input logic [6:0] op);
    case (op)
      OP_R:                     return FMT_R;
      OP_IMM, OP_LOAD, OP_JALR: return FMT_I;
      OP_STORE:                 return FMT_S;
      OP_BRANCH:                return FMT_B;
      OP_LUI, OP_AUIPC:         return FMT_U;
      OP_JAL:                   return FMT_J;
      default:                  return FMT_BAD;
    endcase
  endfunction

  // True when v is representable as a w-bit two's-complement value.
  function automatic logic fitsSigned(input logic [31:0] v, input int w);
    logic [31:0] s;
    s = 32'($signed(v) >>> (w - 1));
    return (s == '0) || (s == '1);
  endfunction
endpackage

// File: rtl/enc_fifo.sv
// enc_fifo: output buffer of encoded words; oReady is registered and reset low.
module enc_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 42,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         iClk,
  input  logic         iRstN,
  input  logic         iFlush,
  input  logic         iPush,
  input  logic         iPop,
  input  logic [W-1:0] iData,
  output logic [W-1:0] oData,
  output logic         oValid,
  output logic         oReady
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [AW:0] count, countNext;
  logic doPush, doPop;
  assign doPush = iPush && count != FULL && !iFlush;
  assign doPop = iPop && count != '0 && !iFlush;
  assign countNext = iFlush ? '0 : count + (AW + 1)'(doPush) - (AW + 1)'(doPop);
  assign oData = mem[rdPtr];
  assign oValid = count != '0;
  always_ff @(posedge iClk or negedge iRstN)
    if (!iRstN) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= RST_VAL;
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      oReady <= 1'b0;
    end else begin
      if (doPush) mem[wrPtr] <= iData;
      wrPtr <= iFlush ? '0 : wrPtr + AW'(doPush);
      rdPtr <= iFlush ? '0 : rdPtr + AW'(doPop);
      count <= countNext;
      oReady <= countNext != FULL;
    end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32I fields into address-tagged instruction words.
// Define INSTR_ENCODER_RANGE_CHECK_EN to flag immediate range and unknown-opcode errors on oErr/oErrAddr.
module instr_encoder
  import rv_isa_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int ADDR_W = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              iClk,
  input  logic              iRstN,
  input  logic              iFlush,
  input  logic              iValid,
  output logic              oReady,
  input  logic [6:0]        iOpcode,
  input  logic [4:0]        iRd,
  input  logic [2:0]        iFunct3,
  input  logic [4:0]        iRs1,
  input  logic [4:0]        iRs2,
  input  logic [6:0]        iFunct7,
  input  logic [31:0]       iImm,
  output logic              oValid,
  input  logic              iReady,
  output logic [31:0]       oInstr,
  output logic [ADDR_W-1:0] oAddr,
  output logic              oErr,
  output logic [ADDR_W-1:0] oErrAddr,
  input  logic              iClrErr
);
  logic accept;
  logic [31:0] word;
  logic immErr;
  logic [ADDR_W-1:0] addr;
  logic [31+ADDR_W:0] head;
  fmtT fmt;
  assign accept = iValid && oReady && !iFlush;
  assign fmt = opFormat(iOpcode);
  always_comb begin
    word = NOP_WORD;
    immErr = 1'b0;
    case (fmt)
      FMT_R: word = {iFunct7, iRs2, iRs1, iFunct3, iRd, iOpcode};
      FMT_I: begin
        word = {iImm[11:0], iRs1, iFunct3, iRd, iOpcode};
        immErr = !fitsSigned(iImm, 12);
      end
      FMT_S: begin
        word = {iImm[11:5], iRs2, iRs1, iFunct3, iImm[4:0], iOpcode};
        immErr = !fitsSigned(iImm, 12);
      end
      FMT_B: begin
        word = {iImm[12], iImm[10:5], iRs2, iRs1, iFunct3, iImm[4:1], iImm[11], iOpcode};
        immErr = !fitsSigned(iImm, 13) || iImm[0];
      end
      FMT_U: begin
        word = {iImm[31:12], iRd, iOpcode};
        immErr = |iImm[11:0];
      end
      FMT_J: begin
        word = {iImm[20], iImm[10:1], iImm[11], iImm[19:12], iRd, iOpcode};
        immErr = !fitsSigned(iImm, 21) || iImm[0];
      end
      default: immErr = 1'b1;
    endcase
  end
  always_ff @(posedge iClk or negedge iRstN)
    if (!iRstN) addr <= BASE_ADDR;
    else if (iFlush) addr <= BASE_ADDR;
    else if (accept) addr <= addr + ADDR_W'(1);
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  // A clear coinciding with a new error re-arms capture so the new address is kept.
  always_ff @(posedge iClk or negedge iRstN)
    if (!iRstN) begin
      oErr <= 1'b0;
      oErrAddr <= '0;
    end else if (accept && immErr) begin
      oErr <= 1'b1;
      if (!oErr || iClrErr) oErrAddr <= addr;
    end else if (iClrErr) begin
      oErr <= 1'b0;
      oErrAddr <= '0;
    end
`else
  logic unusedErr;
  assign unusedErr = immErr ^ iClrErr;
  assign oErr = 1'b0;
  assign oErrAddr = '0;
`endif
  enc_fifo #(
    .DEPTH(DEPTH),
    .W(32 + ADDR_W),
    .RST_VAL({32'h0, BASE_ADDR})
  ) uFifo (
    .iClk(iClk),
    .iRstN(iRstN),
    .iFlush(iFlush),
    .iPush(accept),
    .iPop(iReady),
    .iData({word, addr}),
    .oData(head),
    .oValid(oValid),
    .oReady(oReady)
  );
  assign oInstr = head[31+ADDR_W:ADDR_W];
  assign oAddr = head[ADDR_W-1:0];
endmodule
